// File: rtl/heap_pkg.sv
// Shared definitions for the heap request driver: action codes, error code, FSM states
// and the request record.
package heap_pkg;

    localparam int unsigned ADDRESS_BITS_DEF = 2;
    localparam int unsigned INDEX_BITS_DEF   = 1;
    localparam int unsigned DATA_BITS_DEF    = 12;

    typedef enum logic [7:0] {
        ActReset = 8'd1, ActWrite, ActRead, ActSize, ActInc, ActDec, ActPush, ActPop,
        ActPeek, ActSwap, ActCopy, ActFill, ActClear, ActMin, ActMax, ActSum, ActAdd,
        ActSub, ActMul, ActShl, ActShr, ActNeg, ActNot, ActCmp, ActEq, ActLt, ActGt,
        ActXor, ActOr, ActAnd
    } heap_action_e;

    localparam logic [7:0]  ACTION_MIN     = 8'd1;
    localparam logic [7:0]  ACTION_MAX     = 8'd30;
    localparam logic [31:0] ERR_BAD_ACTION = 32'd10000280;

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, RESPOND} heap_state_e;

    typedef struct packed {
        logic [7:0]                  action;
        logic [ADDRESS_BITS_DEF-1:0] array;
        logic [INDEX_BITS_DEF-1:0]   index;
        logic [DATA_BITS_DEF-1:0]    in;
    } heap_req_t;

    function automatic logic action_valid(input logic [7:0] action);
        return (action >= ACTION_MIN) && (action <= ACTION_MAX);
    endfunction

endpackage

// File: rtl/heap_request_driver_if.sv
// Request and response valid/ready streams of the heap request driver.
interface heap_request_driver_if #(
    parameter int unsigned ADDRESS_BITS = 2,
    parameter int unsigned INDEX_BITS   = 1,
    parameter int unsigned DATA_BITS    = 12
);
    logic                    req_valid;
    logic                    req_ready;
    logic [7:0]              req_action;
    logic [ADDRESS_BITS-1:0] req_array;
    logic [INDEX_BITS-1:0]   req_index;
    logic [DATA_BITS-1:0]    req_in;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_BITS-1:0]    rsp_out;
    logic [31:0]             rsp_error;

    modport master (
        output req_valid, req_action, req_array, req_index, req_in, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_error
    );

    modport slave (
        input  req_valid, req_action, req_array, req_index, req_in, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_error
    );
endinterface

// File: rtl/heap_request_fifo.sv
// Synchronous request FIFO with a registered full flag and no write-to-read bypass.
module heap_request_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned      PTR_BITS   = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] FULL_COUNT = DEPTH[PTR_BITS:0];

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_BITS:0]   count_q, count_d;
    logic                full_q;
    logic                do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && (count_q != '0);
    assign empty   = (count_q == '0);
    assign full    = full_q;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q + {{PTR_BITS{1'b0}}, do_push} - {{PTR_BITS{1'b0}}, do_pop};
    end

    // full resets high so the request side reads not-ready while reset is held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL_COUNT);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/heap_request_driver.sv
// Upstream sequencer for the heap Memory block: queues requests, fires one heapClock
// transition per valid action and returns out/error in acceptance order.
module heap_request_driver
    import heap_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS  = 2,
    parameter int unsigned INDEX_BITS    = 1,
    parameter int unsigned DATA_BITS     = 12,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    heap_request_driver_if.slave    bus,
    output logic                    heapClock,
    output logic [7:0]              heapAction,
    output logic [ADDRESS_BITS-1:0] heapArray,
    output logic [INDEX_BITS-1:0]   heapIndex,
    output logic [DATA_BITS-1:0]    heapIn,
    input  logic [DATA_BITS-1:0]    heapOut,
    input  logic [31:0]             heapError,
    output logic                    busy,
    output logic [31:0]             opsIssued
);
    localparam int unsigned         CNT_BITS    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] SETTLE_LOAD = CNT_BITS'(SETTLE_CYCLES);

    typedef struct packed {
        logic [7:0]              action;
        logic [ADDRESS_BITS-1:0] array;
        logic [INDEX_BITS-1:0]   index;
        logic [DATA_BITS-1:0]    in;
    } req_t;

    heap_state_e          state_q;
    logic [CNT_BITS-1:0]  settle_q, settle_dec;
    logic                 rsp_valid_q;
    logic [DATA_BITS-1:0] rsp_out_q;
    logic [31:0]          rsp_error_q;
    req_t                 head;
    logic                 fifo_full, fifo_empty, pop;

    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign settle_dec = settle_q - 1'b1;

    heap_request_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(req_t))
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (bus.req_valid),
        .wdata ({bus.req_action, bus.req_array, bus.req_index, bus.req_in}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.req_ready = !fifo_full;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_error = rsp_error_q;
    assign busy          = (state_q != IDLE) || !fifo_empty;

    // heapAction resets to 0 so any heapClock edge caused by reset is a Memory no-op.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            heapClock   <= 1'b0;
            heapAction  <= '0;
            heapArray   <= '0;
            heapIndex   <= '0;
            heapIn      <= '0;
            opsIssued   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_error_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (action_valid(head.action)) begin
                            heapAction <= head.action;
                            heapArray  <= head.array;
                            heapIndex  <= head.index;
                            heapIn     <= head.in;
                            state_q    <= DRIVE;
                        end else begin
                            rsp_out_q   <= '0;
                            rsp_error_q <= ERR_BAD_ACTION;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESPOND;
                        end
                    end
                end
                DRIVE: begin
                    heapClock <= ~heapClock;
                    opsIssued <= opsIssued + 32'd1;
                    settle_q  <= SETTLE_LOAD;
                    state_q   <= SETTLE;
                end
                SETTLE: begin
                    settle_q <= settle_dec;
                    if (settle_dec == '0) begin
                        rsp_out_q   <= heapOut;
                        rsp_error_q <= heapError;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_heap_request_driver.sv
// Bench for heap_request_driver: behavioural Memory on the heap pins, in-order reference of
// expected responses, directed scenarios followed by a randomized backpressure run.
module tb_heap_request_driver;
    import heap_pkg::*;

    localparam int unsigned ADDRESS_BITS  = 2;
    localparam int unsigned INDEX_BITS    = 1;
    localparam int unsigned DATA_BITS     = 12;
    localparam int unsigned FIFO_DEPTH    = 4;
    localparam int unsigned SETTLE_CYCLES = 1;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    heapClock;
    logic [7:0]              heapAction;
    logic [ADDRESS_BITS-1:0] heapArray;
    logic [INDEX_BITS-1:0]   heapIndex;
    logic [DATA_BITS-1:0]    heapIn, heapOut;
    logic [31:0]             heapError;
    logic                    busy;
    logic [31:0]             opsIssued;

    heap_request_driver_if #(
        .ADDRESS_BITS (ADDRESS_BITS),
        .INDEX_BITS   (INDEX_BITS),
        .DATA_BITS    (DATA_BITS)
    ) bus ();

    heap_request_driver #(
        .ADDRESS_BITS  (ADDRESS_BITS),
        .INDEX_BITS    (INDEX_BITS),
        .DATA_BITS     (DATA_BITS),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .heapClock  (heapClock),
        .heapAction (heapAction),
        .heapArray  (heapArray),
        .heapIndex  (heapIndex),
        .heapIn     (heapIn),
        .heapOut    (heapOut),
        .heapError  (heapError),
        .busy       (busy),
        .opsIssued  (opsIssued)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DATA_BITS-1:0] out;
        logic [31:0]          err;
    } rsp_t;

    int                   checks = 0;
    int                   errors = 0;
    rsp_t                 exp_q[$];
    logic [DATA_BITS-1:0] mem     [4][2];
    logic [DATA_BITS-1:0] ref_mem [4][2];
    int                   mem_ops  = 0;
    int                   exp_ops  = 0;
    int                   ops_base = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behaviour of one Memory operation on the addressed element.
    function automatic void calc(input heap_req_t r, input logic [DATA_BITS-1:0] cur,
                                 output logic [DATA_BITS-1:0] nv, output logic wr,
                                 output logic [DATA_BITS-1:0] o, output logic [31:0] e);
        nv = cur; wr = 1'b0; o = '0; e = '0;
        case (r.action)
            ActReset: begin nv = '0; wr = 1'b1; end
            ActWrite: begin nv = r.in; wr = 1'b1; o = r.in; end
            ActRead:  o = cur;
            ActSize:  o = DATA_BITS'(2 ** INDEX_BITS);
            ActInc:   begin nv = cur + 1'b1; wr = 1'b1; end
            ActDec:   begin nv = cur - 1'b1; wr = 1'b1; end
            default:  begin o = cur ^ r.in; e = 32'(r.action); end
        endcase
    endfunction

    initial begin : memory_model
        heap_req_t            r;
        logic [DATA_BITS-1:0] nv;
        logic                 wr;
        for (int a = 0; a < 4; a++) for (int i = 0; i < 2; i++) mem[a][i] = '0;
        heapOut   = '0;
        heapError = '0;
        forever begin
            @(heapClock);
            #1;
            if (heapAction >= ACTION_MIN && heapAction <= ACTION_MAX) begin
                r.action = heapAction; r.array = heapArray; r.index = heapIndex; r.in = heapIn;
                calc(r, mem[heapArray][heapIndex], nv, wr, heapOut, heapError);
                if (wr) mem[heapArray][heapIndex] = nv;
                mem_ops++;
            end
        end
    end

    task automatic ref_accept(input heap_req_t r);
        rsp_t                 e;
        logic [DATA_BITS-1:0] nv;
        logic                 wr;
        if (r.action >= ACTION_MIN && r.action <= ACTION_MAX) begin
            calc(r, ref_mem[r.array][r.index], nv, wr, e.out, e.err);
            if (wr) ref_mem[r.array][r.index] = nv;
            exp_ops++;
        end else begin
            e.out = '0;
            e.err = ERR_BAD_ACTION;
        end
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] act, input logic [1:0] arr, input logic idx,
                        input logic [DATA_BITS-1:0] din);
        heap_req_t r;
        int        n = 0;
        r.action = act; r.array = arr; r.index = idx; r.in = din;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_action = act; bus.req_array = arr;
        bus.req_index = idx;  bus.req_in = din;
        while (!bus.req_ready && n < 100) begin @(negedge clock); n++; end
        if (!bus.req_ready) check("req_accept_timeout", 32'(bus.req_ready), 32'd1);
        else begin
            ref_accept(r);
            @(posedge clock);
            #1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input bit rnd);
        rsp_t e;
        int   n    = 0;
        bit   done = 1'b0;
        while (!done) begin
            @(negedge clock);
            bus.rsp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) check({tag, "_unexpected"}, 32'(bus.rsp_valid), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check({tag, "_out"}, 32'(bus.rsp_out), 32'(e.out));
                    check({tag, "_err"}, bus.rsp_error, e.err);
                end
                done = 1'b1;
            end else begin
                n++;
                if (n > 200) begin
                    check({tag, "_timeout"}, 32'(bus.rsp_valid), 32'd1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clock);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic check_ops(input string tag);
        check({tag, "_opsIssued"}, opsIssued, 32'(exp_ops));
        check({tag, "_mem_ops"}, 32'(mem_ops - ops_base), 32'(exp_ops));
        check({tag, "_heapClock"}, 32'(heapClock), 32'(exp_ops % 2));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin : stimulus
        int   lat;
        rsp_t e;

        bus.req_valid = 1'b0; bus.req_action = '0; bus.req_array = '0;
        bus.req_index = '0;   bus.req_in = '0;     bus.rsp_ready = 1'b0;
        for (int a = 0; a < 4; a++) for (int i = 0; i < 2; i++) ref_mem[a][i] = '0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_heapClock", 32'(heapClock), 32'd0);
        check("rst_heapAction", 32'(heapAction), 32'd0);
        check("rst_opsIssued", opsIssued, 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_error", bus.rsp_error, 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        ops_base = mem_ops;
        @(negedge clock);
        check("rst_req_ready_after", 32'(bus.req_ready), 32'd1);

        // 1: single Write, latency and one transition
        send(ActWrite, 2'd1, 1'b0, 12'h0A5);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin @(posedge clock); #1; lat++; end
        check("t1_latency", 32'(lat), 32'd3);
        check_ops("t1");
        check("t1_opsIssued_one", opsIssued, 32'd1);
        recv("t1", 1'b0);

        // 2: Write, Read, Size in order
        send(ActWrite, 2'd2, 1'b1, 12'h123);
        send(ActRead, 2'd2, 1'b1, 12'h000);
        send(ActSize, 2'd2, 1'b0, 12'h000);
        repeat (3) recv("t2", 1'b0);
        check("t2_opsIssued_three", opsIssued, 32'd4);
        check_ops("t2");

        // 3: backpressure fills FIFO plus the in-flight slot
        send(ActWrite, 2'd0, 1'b0, 12'h111);
        send(ActInc, 2'd0, 1'b0, 12'h000);
        send(ActRead, 2'd0, 1'b0, 12'h000);
        send(ActDec, 2'd3, 1'b1, 12'h000);
        send(ActSize, 2'd3, 1'b0, 12'h000);
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_action = ActRead; bus.req_array = 2'd0;
        bus.req_index = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_req_ready_low", 32'(bus.req_ready), 32'd0);
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        fork
            send(ActRead, 2'd0, 1'b0, 12'h000);
            repeat (6) recv("t3", 1'b0);
        join
        check_ops("t3");

        // 4: undecoded actions answer locally without touching Memory
        send(8'd31, 2'd1, 1'b0, 12'hFFF);
        recv("t4_a31", 1'b0);
        send(8'd0, 2'd1, 1'b0, 12'hFFF);
        recv("t4_a0", 1'b0);
        check_ops("t4");

        // 5: reset while the operation is settling
        send(ActWrite, 2'd3, 1'b1, 12'h777);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("t5_heapClock", 32'(heapClock), 32'd0);
        check("t5_heapAction", 32'(heapAction), 32'd0);
        check("t5_opsIssued", opsIssued, 32'd0);
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        exp_q.delete();
        exp_ops = 0;
        @(negedge clock);
        reset = 1'b1;
        #3 ops_base = mem_ops;
        repeat (10) @(negedge clock);
        check("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        send(ActRead, 2'd1, 1'b0, 12'h000);
        check("t5_ref_a5", 32'(exp_q[0].out), 32'h0A5);
        recv("t5_read", 1'b0);
        check_ops("t5");

        // 6: response held stable under backpressure
        send(ActRead, 2'd2, 1'b1, 12'h000);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin @(posedge clock); #1; lat++; end
        e = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("t6_valid", 32'(bus.rsp_valid), 32'd1);
            check("t6_out", 32'(bus.rsp_out), 32'(e.out));
            check("t6_err", bus.rsp_error, e.err);
            check("t6_heapClock", 32'(heapClock), 32'(exp_ops % 2));
        end
        recv("t6", 1'b0);

        // Randomized traffic with random gaps and response backpressure
        fork
            for (int k = 0; k < 40; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
                send(($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(1, 30)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     12'($urandom_range(0, 4095)));
            end
            for (int k = 0; k < 40; k++) recv("rnd", 1'b1);
        join
        repeat (2) @(negedge clock);
        check_ops("rnd");
        check("rnd_busy", 32'(busy), 32'd0);
        check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
